// File: rtl/vbsme_loader.sv
// ---------------------------------------------------------------------------
// vbsme_loader
//
// Receives a byte stream (valid/ready handshake) holding a header, a
// FRAME_DIM x FRAME_DIM frame and a WIN_DIM x WIN_DIM search window. It writes
// every accepted byte into a byte-addressed data memory at its stream index.
// The header is checked against the expected dimensions. A 16-bit running sum
// of the frame and window bytes is kept.
//
// Ports
//   Clk       in   sole clock, rising edge
//   Rst_n     in   asynchronous active-low reset
//   Start     in   begin a load (honoured in IDLE, DONE or ERR only)
//   InData    in   [7:0] streamed byte
//   InValid   in   InData valid
//   InReady   out  loader accepts a byte this cycle (HDR/FRAME/WIN)
//   MemAddr   out  [12:0] memory byte address of the write
//   MemData   out  [7:0] memory write data
//   MemWe     out  write strobe, one byte per asserted cycle
//   Busy      out  load in progress
//   Done      out  one-cycle pulse alongside the final window write
//   Err       out  header mismatch (level, cleared by Start)
//   Checksum  out  [15:0] modulo-2^16 sum of frame and window bytes
// ---------------------------------------------------------------------------
module vbsme_loader #(
  parameter int FRAME_DIM = 64,
  parameter int WIN_DIM   = 4,
  parameter int HDR_BYTES = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [7:0]  InData,
  input  logic        InValid,
  output logic        InReady,
  output logic [12:0] MemAddr,
  output logic [7:0]  MemData,
  output logic        MemWe,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [15:0] Checksum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_FRAME = 3'd2,
    S_WIN   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Stream indices of the last byte of each section
  localparam logic [12:0] HDR_LAST   = 13'(HDR_BYTES - 1);
  localparam logic [12:0] FRAME_LAST = 13'(HDR_BYTES + FRAME_DIM * FRAME_DIM - 1);
  localparam logic [12:0] WIN_LAST   = 13'(HDR_BYTES + FRAME_DIM * FRAME_DIM
                                           + WIN_DIM * WIN_DIM - 1);

  state_t       state_r;
  state_t       state_s;
  logic         accept_s;
  logic         start_s;
  logic         hdr_byte_ok_s;
  logic [12:0]  cnt_r;
  logic         hdr_ok_r;
  logic         in_ready_r;
  logic         busy_r;
  logic         mem_we_r;
  logic [12:0]  mem_addr_r;
  logic [7:0]   mem_data_r;
  logic         done_r;
  logic         err_r;
  logic [15:0]  checksum_r;

  // Expected header: FRAME_DIM, FRAME_DIM, WIN_DIM, WIN_DIM. Any header bytes
  // beyond the fourth are stored but not checked.
  function automatic logic hdr_match(input logic [12:0] idx, input logic [7:0] data);
    logic ok_v;
    case (idx)
      13'd0, 13'd1: ok_v = (data == 8'(FRAME_DIM));
      13'd2, 13'd3: ok_v = (data == 8'(WIN_DIM));
      default:      ok_v = 1'b1;
    endcase
    return ok_v;
  endfunction

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic, byte acceptance and Start decode
  always_comb begin
    state_s       = state_r;
    start_s       = 1'b0;
    accept_s      = InValid & in_ready_r;
    hdr_byte_ok_s = hdr_match(cnt_r, InData);
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_s = S_HDR;
          start_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      S_HDR: begin
        if (accept_s && (cnt_r == HDR_LAST)) begin
          // The verdict folds in the byte being accepted right now
          state_s = (hdr_ok_r && hdr_byte_ok_s) ? S_FRAME : S_ERR;
        end else begin
          state_s = S_HDR;
        end
      end
      S_FRAME: begin
        if (accept_s && (cnt_r == FRAME_LAST)) begin
          state_s = S_WIN;
        end else begin
          state_s = S_FRAME;
        end
      end
      S_WIN: begin
        if (accept_s && (cnt_r == WIN_LAST)) begin
          state_s = S_DONE;
        end else begin
          state_s = S_WIN;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Datapath: byte counter, header check, checksum and registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_r      <= 13'd0;
      hdr_ok_r   <= 1'b1;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= 13'd0;
      mem_data_r <= 8'd0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      checksum_r <= 16'd0;
    end else begin
      // Ready/Busy follow the state being entered, so they line up with it
      in_ready_r <= (state_s == S_HDR) || (state_s == S_FRAME) || (state_s == S_WIN);
      busy_r     <= (state_s == S_HDR) || (state_s == S_FRAME) || (state_s == S_WIN);
      mem_we_r   <= accept_s;
      done_r     <= (state_r == S_WIN) && (state_s == S_DONE);
      err_r      <= (state_s == S_ERR);
      if (start_s) begin
        cnt_r      <= 13'd0;
        hdr_ok_r   <= 1'b1;
        checksum_r <= 16'd0;
      end else if (accept_s) begin
        cnt_r      <= cnt_r + 13'd1;
        mem_addr_r <= cnt_r;
        mem_data_r <= InData;
        if (state_r == S_HDR) begin
          hdr_ok_r <= hdr_ok_r & hdr_byte_ok_s;
        end else begin
          checksum_r <= checksum_r + {8'h00, InData};
        end
      end else begin
        cnt_r      <= cnt_r;
        checksum_r <= checksum_r;
      end
    end
  end

  assign InReady  = in_ready_r;
  assign Busy     = busy_r;
  assign MemWe    = mem_we_r;
  assign MemAddr  = mem_addr_r;
  assign MemData  = mem_data_r;
  assign Done     = done_r;
  assign Err      = err_r;
  assign Checksum = checksum_r;

endmodule
